// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC-8 arbiter and its bit-serial divider.
// crc_step is one MSB-first division step: feedback is rem[7] xor the incoming message bit.
package crc_pkg;

  localparam int CRC_W = 8;
  localparam int N_REQ = 2;
  localparam logic [CRC_W-1:0] DEF_POLY = 8'h07;
  localparam logic [CRC_W-1:0] DEF_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] rem,
    input logic             din,
    input logic [CRC_W-1:0] poly
  );
    logic fb;
    fb = rem[CRC_W-1] ^ din;
    return {rem[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc8_shift.sv
// Bit-serial CRC-8 divider: clear loads INIT, load latches a message byte,
// shift_en consumes one message bit per cycle, MSB first.
module crc8_shift
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT = DEF_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic [CRC_W-1:0] din,
  output logic [CRC_W-1:0] rem,
  output logic             msg_msb,
  output logic [2:0]       bit_cnt
);

  logic [CRC_W-1:0] rem_q, rem_d;
  logic [CRC_W-1:0] sh_q, sh_d;
  logic [2:0]       cnt_q, cnt_d;

  always_comb begin
    rem_d = rem_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear) begin
      rem_d = INIT;
    end
    if (load) begin
      sh_d  = din;
      cnt_d = 3'd7;
    end else if (shift_en) begin
      rem_d = crc_step(rem_q, sh_q[CRC_W-1], POLY);
      sh_d  = {sh_q[CRC_W-2:0], 1'b0};
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= INIT;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign rem     = rem_q;
  assign msg_msb = sh_q[CRC_W-1];
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/crc_arbiter.sv
// Round-robin two-requester frame scheduler in front of the bit-serial CRC-8 divider.
// All handshake and result outputs are registered, derived from the next-state value.
module crc_arbiter
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT = DEF_INIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CRC_W-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [CRC_W-1:0]       res_crc,
  output logic                   res_id,
  output logic                   busy
);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             last_q, last_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [CRC_W-1:0] res_crc_q, res_crc_d;
  logic             res_id_q, res_id_d;
  logic             busy_q, busy_d;

  logic [CRC_W-1:0] req_byte [N_REQ];
  logic             accept;
  logic             div_clear, div_load, div_shift;
  logic [CRC_W-1:0] div_rem;
  logic             div_msb;
  logic [2:0]       div_cnt;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte
    assign req_byte[gi] = req_data[gi*CRC_W +: CRC_W];
  end

  assign accept = req_valid[grant_q] & req_ready_q[grant_q];

  crc8_shift #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_div (
    .clk      (clock),
    .rst_n    (reset),
    .clear    (div_clear),
    .load     (div_load),
    .shift_en (div_shift),
    .din      (req_byte[grant_q]),
    .rem      (div_rem),
    .msg_msb  (div_msb),
    .bit_cnt  (div_cnt)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    res_crc_d    = res_crc_q;
    res_id_d     = res_id_q;
    div_clear    = 1'b0;
    div_load     = 1'b0;
    div_shift    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          // On a tie the requester not served last wins; otherwise the lone requester.
          grant_d   = (&req_valid) ? ~last_grant_q : req_valid[1];
          div_clear = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          div_load = 1'b1;
          last_d   = req_last[grant_q];
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        div_shift = 1'b1;
        if (div_cnt == 3'd0) begin
          if (last_q) begin
            // Capture the remainder including this final shift so it is valid in DONE.
            res_crc_d = crc_step(div_rem, div_msb, POLY);
            res_id_d  = grant_q;
            state_d   = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = '0;
    if (state_d == LOAD) begin
      req_ready_d[grant_d] = 1'b1;
    end
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      last_q       <= 1'b0;
      req_ready_q  <= '0;
      res_valid_q  <= 1'b0;
      res_crc_q    <= '0;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      req_ready_q  <= req_ready_d;
      res_valid_q  <= res_valid_d;
      res_crc_q    <= res_crc_d;
      res_id_q     <= res_id_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_crc   = res_crc_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule
